// File: rtl/sdram_tb_pkg.sv
// sdram_tb_pkg: driver FSM states, response error codes and SDRAM address-field layout
package sdram_tb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [1:0] ERR_OK = 2'd0;
  localparam logic [1:0] ERR_ADDR = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] MMIO_TAG = 2'b10;
  localparam int TAG_HI = 31;
  localparam int TAG_LO = 30;
  localparam int RSV_HI = 29;
  localparam int RSV_LO = 25;
  localparam int COL_HI = 24;
  localparam int COL_LO = 16;
  localparam int BANK_HI = 15;
  localparam int BANK_LO = 14;
  localparam int ROW_HI = 13;
  localparam int ROW_LO = 0;
  function automatic logic addr_ok(input logic [31:0] a);
    return a[TAG_HI:TAG_LO] == MMIO_TAG && a[RSV_HI:RSV_LO] == '0;
  endfunction
endpackage

// File: rtl/sdram_cmd_fifo.sv
// sdram_cmd_fifo: synchronous show-ahead FIFO holding driver commands
// ports: clk/rst, push+din, pop, dout (head entry), full, empty, count (occupancy)
module sdram_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 65,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/sdram_txn_driver.sv
// sdram_txn_driver: queues bus commands and issues them one at a time on HSEL/HWRITE/HADDR/HWDATA
// ports: in_cmd_* command in (valid/ready), out_H*/in_H* bus side, out_rsp_*/in_rsp_ready response out,
//        out_count FIFO occupancy, out_busy FSM not idle
module sdram_txn_driver
  import sdram_tb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                     in_HCLK,
  input  logic                     in_HRESET,
  input  logic                     in_cmd_valid,
  output logic                     out_cmd_ready,
  input  logic                     in_cmd_write,
  input  logic [31:0]              in_cmd_addr,
  input  logic [31:0]              in_cmd_wdata,
  output logic                     out_HSEL,
  output logic                     out_HWRITE,
  output logic [31:0]              out_HADDR,
  output logic [31:0]              out_HWDATA,
  input  logic                     in_HREADY,
  input  logic [31:0]              in_HRDATA,
  output logic                     out_rsp_valid,
  input  logic                     in_rsp_ready,
  output logic                     out_rsp_write,
  output logic [31:0]              out_rsp_addr,
  output logic [31:0]              out_rsp_rdata,
  output logic [1:0]               out_rsp_err,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic                     out_busy
);
  localparam logic [15:0] TO = 16'(TIMEOUT);
  state_t state, state_n;
  logic [15:0] timer, timer_n;
  logic full, empty, pop;
  logic [64:0] head;
  logic head_write;
  logic [31:0] head_addr, head_wdata;
  logic hsel_n, hwrite_n, rsp_write_n;
  logic [31:0] haddr_n, hwdata_n, rsp_addr_n, rsp_rdata_n;
  logic [1:0] rsp_err_n;
  assign out_cmd_ready = !full && !in_HRESET;
  assign {head_write, head_addr, head_wdata} = head;
  sdram_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(65)) u_fifo (
    .clk(in_HCLK),
    .rst(in_HRESET),
    .push(in_cmd_valid && out_cmd_ready),
    .pop(pop),
    .din({in_cmd_write, in_cmd_addr, in_cmd_wdata}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(out_count)
  );
  always_ff @(posedge in_HCLK) begin
    if (in_HRESET) begin
      state <= IDLE;
      timer <= '0;
      out_HSEL <= 1'b0;
      out_HWRITE <= 1'b0;
      out_HADDR <= '0;
      out_HWDATA <= '0;
      out_rsp_valid <= 1'b0;
      out_rsp_write <= 1'b0;
      out_rsp_addr <= '0;
      out_rsp_rdata <= '0;
      out_rsp_err <= ERR_OK;
      out_busy <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      out_HSEL <= hsel_n;
      out_HWRITE <= hwrite_n;
      out_HADDR <= haddr_n;
      out_HWDATA <= hwdata_n;
      out_rsp_valid <= state_n == RESP;
      out_rsp_write <= rsp_write_n;
      out_rsp_addr <= rsp_addr_n;
      out_rsp_rdata <= rsp_rdata_n;
      out_rsp_err <= rsp_err_n;
      out_busy <= state_n != IDLE;
    end
  end
  always_comb begin
    state_n = state;
    timer_n = timer;
    pop = 1'b0;
    hsel_n = out_HSEL;
    hwrite_n = out_HWRITE;
    haddr_n = out_HADDR;
    hwdata_n = out_HWDATA;
    rsp_write_n = out_rsp_write;
    rsp_addr_n = out_rsp_addr;
    rsp_rdata_n = out_rsp_rdata;
    rsp_err_n = out_rsp_err;
    unique case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        rsp_write_n = head_write;
        rsp_addr_n = head_addr;
        rsp_rdata_n = '0;
        // a malformed address is answered straight away without driving the bus
        if (addr_ok(head_addr)) begin
          state_n = ISSUE;
          hsel_n = 1'b1;
          hwrite_n = head_write;
          haddr_n = head_addr;
          hwdata_n = head_wdata;
          rsp_err_n = ERR_OK;
        end else begin
          state_n = RESP;
          rsp_err_n = ERR_ADDR;
        end
      end
      ISSUE: begin
        state_n = WAIT;
        timer_n = 16'd1;
      end
      WAIT: if (in_HREADY || timer == TO) begin
        state_n = RESP;
        hsel_n = 1'b0;
        hwrite_n = 1'b0;
        haddr_n = '0;
        hwdata_n = '0;
        rsp_err_n = in_HREADY ? ERR_OK : ERR_TIMEOUT;
        rsp_rdata_n = (in_HREADY && !out_HWRITE) ? in_HRDATA : '0;
      end else timer_n = timer + 16'd1;
      RESP: if (in_rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sdram_txn_driver.sv
// tb_sdram_txn_driver: scoreboard bench with a memory-backed bus responder and a response monitor
module tb_sdram_txn_driver;
  localparam int DEPTH = 8;
  localparam int TIMEOUT = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, hready = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, hrdata = '0;
  logic cmd_ready, hsel, hwrite, rsp_valid, rsp_write, busy;
  logic [31:0] haddr, hwdata, rsp_addr, rsp_rdata;
  logic [1:0] rsp_err;
  logic [3:0] count;
  int checks = 0, errors = 0;
  int rdy_mode = 2, fixed_d = -1;
  logic [66:0] rsp_q[$];
  logic [64:0] bus_q[$];
  logic [31:0] mmem[logic [31:0]];
  logic [31:0] rmem[logic [31:0]];

  sdram_txn_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .in_HCLK(clk), .in_HRESET(rst),
    .in_cmd_valid(cmd_valid), .out_cmd_ready(cmd_ready), .in_cmd_write(cmd_write),
    .in_cmd_addr(cmd_addr), .in_cmd_wdata(cmd_wdata),
    .out_HSEL(hsel), .out_HWRITE(hwrite), .out_HADDR(haddr), .out_HWDATA(hwdata),
    .in_HREADY(hready), .in_HRDATA(hrdata),
    .out_rsp_valid(rsp_valid), .in_rsp_ready(rsp_ready), .out_rsp_write(rsp_write),
    .out_rsp_addr(rsp_addr), .out_rsp_rdata(rsp_rdata), .out_rsp_err(rsp_err),
    .out_count(count), .out_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [66:0] act, logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dflt(logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // reference: commands complete strictly in order; a memory answers reads,
  // addresses ending in nibble F never get HREADY and so time out
  task automatic model(logic w, logic [31:0] a, logic [31:0] d);
    if (!(a[31:30] == 2'b10 && a[29:25] == 5'd0))
      rsp_q.push_back({w, a, 32'd0, 2'd1});
    else begin
      bus_q.push_back({w, a, d});
      if (a[3:0] == 4'hF) rsp_q.push_back({w, a, 32'd0, 2'd2});
      else if (w) begin
        mmem[a] = d;
        rsp_q.push_back({w, a, 32'd0, 2'd0});
      end else rsp_q.push_back({w, a, mmem.exists(a) ? mmem[a] : dflt(a), 2'd0});
    end
  endtask

  // bus responder
  int cnt = 0, gap = 2, dly = 0;
  logic [64:0] lat, be;
  always @(negedge clk) begin
    if (rst) begin
      cnt = 0;
      gap = 2;
      hready = 1'b0;
    end else if (hsel) begin
      if (cnt == 0) begin
        chk("hsel_gap", 67'(gap >= 2), 67'd1);
        lat = {hwrite, haddr, hwdata};
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got transfer to %0h expected none", haddr);
        end else begin
          be = bus_q.pop_front();
          chk("bus_cmd", 67'({hwrite, haddr}), 67'(be[64:32]));
          if (hwrite) chk("bus_wdata", 67'(hwdata), 67'(be[31:0]));
        end
        dly = fixed_d >= 0 ? fixed_d : int'($urandom_range(0, 7));
      end else chk("bus_hold", 67'({hwrite, haddr, hwdata}), 67'(lat));
      cnt++;
      hready = lat[35:32] != 4'hF && cnt > dly;
      hrdata = rmem.exists(lat[63:32]) ? rmem[lat[63:32]] : dflt(lat[63:32]);
    end else begin
      if (cnt > 0) begin
        chk("hsel_cycles", 67'(cnt), 67'(lat[35:32] == 4'hF ? TIMEOUT + 1 : (dly + 1 > 2 ? dly + 1 : 2)));
        if (lat[64] && lat[35:32] != 4'hF) rmem[lat[63:32]] = lat[31:0];
        gap = 0;
      end
      cnt = 0;
      gap++;
      hready = 1'b0;
      hrdata = $urandom;
    end
  end

  // response monitor
  logic [66:0] re;
  always @(negedge clk) begin
    if (rst) rsp_ready = 1'b0;
    else begin
      rsp_ready = rdy_mode == 0 ? ($urandom_range(0, 3) != 0) : (rdy_mode == 2);
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got response for %0h expected none", rsp_addr);
        end else begin
          re = rsp_q.pop_front();
          chk("rsp_write", 67'(rsp_write), 67'(re[66]));
          chk("rsp_addr", 67'(rsp_addr), 67'(re[65:34]));
          chk("rsp_rdata", 67'(rsp_rdata), 67'(re[33:2]));
          chk("rsp_err", 67'(rsp_err), 67'(re[1:0]));
        end
      end
    end
  end

  task automatic send(logic w, logic [31:0] a, logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: got ready 0 expected 1 within 3000 cycles");
    end else model(w, a, d);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    cmd_valid = 1'b0;
    while ((rsp_q.size() != 0 || busy || count != 0 || hsel) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 67'(n < 5000), 67'd1);
    chk("bus_q_empty", 67'(bus_q.size()), 67'd0);
  endtask

  task automatic rst_checks(string tag);
    chk({tag, "_bus"}, 67'({hsel, hwrite, haddr, hwdata}), '0);
    chk({tag, "_rsp"}, 67'({rsp_valid, rsp_write, rsp_err, rsp_rdata}), '0);
    chk({tag, "_rsp_addr"}, 67'(rsp_addr), '0);
    chk({tag, "_count_busy"}, 67'({count, busy}), '0);
    chk({tag, "_ready_in_rst"}, 67'(cmd_ready), '0);
  endtask

  function automatic logic [31:0] raddr();
    logic [31:0] a;
    a = {2'b10, 5'd0, 9'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 10'd0, 4'($urandom_range(0, 15))};
    if ($urandom_range(0, 9) == 0) a[31:25] = $urandom_range(0, 1) != 0 ? 7'b0100000 : 7'b1000001;
    return a;
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    rst_checks("reset");
    rst = 1'b0;
    #1 chk("ready_after_reset", 67'(cmd_ready), 67'd1);
    @(negedge clk);
    // single write then read, HREADY at first legal cycle
    rdy_mode = 2;
    fixed_d = 0;
    send(1'b1, 32'h8000_0000, 32'h4985_6712);
    send(1'b0, 32'h8000_0000, 32'h0);
    drain();
    fixed_d = -1;
    // bad addresses: answered one cycle after pop, bus untouched
    send(1'b0, 32'h4000_0000, 32'h0);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("bad_tag_rsp", 67'({rsp_valid, rsp_err, hsel}), 67'({1'b1, 2'd1, 1'b0}));
    send(1'b1, 32'h8200_0000, 32'h1234);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("bad_rsv_rsp", 67'({rsp_valid, rsp_err, hsel}), 67'({1'b1, 2'd1, 1'b0}));
    drain();
    // timeout then a normal command
    send(1'b0, 32'h8000_000F, 32'h0);
    send(1'b1, 32'h8000_0010, 32'hCAFE_0001);
    drain();
    // FIFO full under response backpressure
    rdy_mode = 1;
    for (int i = 0; i < 9; i++) send(1'b1, 32'h8000_0000 | 32'(i << 4), $urandom);
    chk("full_ready", 67'(cmd_ready), 67'd0);
    chk("full_count", 67'(count), 67'd8);
    rdy_mode = 0;
    send(1'b0, 32'h8000_0020, 32'h0);
    drain();
    // reset while a transfer hangs in WAIT with 3 commands queued
    rdy_mode = 2;
    send(1'b0, 32'h8000_003F, 32'h0);
    send(1'b0, 32'h8000_0040, 32'h0);
    send(1'b0, 32'h8000_0050, 32'h0);
    send(1'b0, 32'h8000_0060, 32'h0);
    cmd_valid = 1'b0;
    chk("pre_reset_state", 67'({hsel, count}), 67'({1'b1, 4'd3}));
    rst = 1'b1;
    rsp_q.delete();
    bus_q.delete();
    @(negedge clk);
    rst_checks("midwait_reset");
    rst = 1'b0;
    #1 chk("ready_after_midwait_reset", 67'(cmd_ready), 67'd1);
    repeat (20) @(negedge clk);
    chk("post_reset_quiet", 67'({hsel, rsp_valid, count, busy}), '0);
    // long HREADY delay: bus held stable, gap before next issue
    fixed_d = 7;
    send(1'b1, 32'h8001_0020, 32'h5A5A_1234);
    send(1'b0, 32'h8001_0020, 32'h0);
    drain();
    fixed_d = -1;
    // randomized traffic with random backpressure
    rdy_mode = 0;
    for (int i = 0; i < 200; i++) begin
      send(1'($urandom_range(0, 1)), raddr(), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
